// File: rtl/demux_pkg.sv
// Shared definitions for the demux lane packer: lane count,
// lane-index width/type and the output register state encoding.
package demux_pkg;

   localparam int LANES  = 4;
   localparam int LANE_W = 2;

   typedef logic [LANE_W-1:0] lane_t;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/lane_accum.sv
// Per-lane serial-to-parallel accumulator with bit counter.
// Ports: clk, rst_n (async, active-low), flush_i (sync clear),
//        beat_i (accepted beat for this lane), bit_i (data bit),
//        done_o (this beat completes the word), word_o (word incl. bit_i).
module lane_accum #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             beat_i,
   input  logic             bit_i,
   output logic             done_o,
   output logic [WIDTH-1:0] word_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             last;

   assign last = (cnt_q == LAST);

   always_comb begin
      // word_o is the accumulator with the current bit merged in,
      // so a completing beat can hand over the full word directly.
      word_o        = acc_q;
      word_o[cnt_q] = bit_i;
      done_o        = beat_i && !flush_i && last;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      if (flush_i) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (beat_i) begin
         if (last) begin
            cnt_d = '0;
            acc_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = word_o;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/demux_lane_packer.sv
// Packs bits from a 1:4 demux into per-lane WIDTH-bit words.
// Ports: clk, rst_n, s0/s1 lane select, y0..y3 demux outputs,
//        in_valid/in_ready input beat handshake, flush,
//        out_valid/out_ready/out_data/out_lane completed word.
module demux_lane_packer
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s0,
   input  logic             s1,
   input  logic             y0,
   input  logic             y1,
   input  logic             y2,
   input  logic             y3,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_lane
);

   lane_t            sel;
   logic [LANES-1:0] y_vec;
   logic [LANES-1:0] done_vec;
   logic [WIDTH-1:0] word_arr [LANES];
   logic             accept;
   logic             complete;

   out_state_e       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   lane_t            lane_q, lane_d;

   assign sel   = {s1, s0};
   assign y_vec = {y3, y2, y1, y0};

   // Flush wins over a same-cycle beat: the beat is dropped.
   assign accept = in_valid && in_ready && !flush;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      lane_accum #(
         .WIDTH (WIDTH)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .flush_i (flush),
         .beat_i  (accept && (sel == lane_t'(g))),
         .bit_i   (y_vec[g]),
         .done_o  (done_vec[g]),
         .word_o  (word_arr[g])
      );
   end

   assign complete  = |done_vec;
   assign out_valid = (state_q == OUT_FULL);
   assign in_ready  = !(out_valid && !out_ready);
   assign out_data  = data_q;
   assign out_lane  = lane_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      lane_d  = lane_q;
      unique case (state_q)
         OUT_EMPTY: begin
            if (complete) begin
               state_d = OUT_FULL;
               data_d  = word_arr[sel];
               lane_d  = sel;
            end
         end
         OUT_FULL: begin
            // A completion here implies out_ready, since in_ready
            // blocks all beats while the word is stalled.
            if (complete) begin
               data_d = word_arr[sel];
               lane_d = sel;
            end else if (out_ready) begin
               state_d = OUT_EMPTY;
            end
         end
         default: state_d = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OUT_EMPTY;
         data_q  <= '0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         lane_q  <= lane_d;
      end
   end

endmodule

// File: tb/tb_demux_lane_packer.sv
// Directed bench for demux_lane_packer (WIDTH=8): vector table
// plus hand-written stall, flush and async-reset sequences.
module tb_demux_lane_packer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s0, s1, y0, y1, y2, y3;
   logic       in_valid, in_ready, flush;
   logic       out_valid, out_ready;
   logic [7:0] out_data;
   logic [1:0] out_lane;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic       v;
      logic [1:0] ln;
      logic       b;
      logic       fl;
      logic       ordy;
      logic       ev;
      logic [7:0] ed;
      logic [1:0] el;
      logic       eir;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   demux_lane_packer #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s0        (s0),
      .s1        (s1),
      .y0        (y0),
      .y1        (y1),
      .y2        (y2),
      .y3        (y3),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_lane  (out_lane)
   );

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Non-selected lanes see the inverted bit so ignoring them matters.
   task automatic drive(input logic v, input logic [1:0] ln,
                        input logic b, input logic fl,
                        input logic ordy);
      logic [3:0] yv;
      yv       = {4{~b}};
      yv[ln]   = b;
      {y3, y2, y1, y0} = yv;
      {s1, s0} = ln;
      in_valid = v;
      flush    = fl;
      out_ready = ordy;
   endtask

   task automatic step(input string nm, input logic v,
                       input logic [1:0] ln, input logic b,
                       input logic fl, input logic ordy,
                       input logic ev, input logic [7:0] ed,
                       input logic [1:0] el, input logic eir);
      @(negedge clk);
      drive(v, ln, b, fl, ordy);
      @(posedge clk);
      #1;
      check({nm, " out_valid"}, 32'(out_valid), 32'(ev));
      if (ev) begin
         check({nm, " out_data"}, 32'(out_data), 32'(ed));
         check({nm, " out_lane"}, 32'(out_lane), 32'(el));
      end
      check({nm, " in_ready"}, 32'(in_ready), 32'(eir));
   endtask

   function automatic vec_t mk(logic v, logic [1:0] ln, logic b,
                               logic fl, logic ordy, logic ev,
                               logic [7:0] ed, logic [1:0] el,
                               logic eir);
      vec_t r;
      r.v = v; r.ln = ln; r.b = b; r.fl = fl; r.ordy = ordy;
      r.ev = ev; r.ed = ed; r.el = el; r.eir = eir;
      return r;
   endfunction

   initial begin
      logic [7:0] pat;
      logic [1:0] ln;

      // lane 0: bits 1,0,1,1,0,0,1,0 -> 8'h4D
      pat = 8'b0100_1101;
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(1, 2'd0, pat[k], 0, 1,
                          k == 7, 8'h4D, 2'd0, 1));
      tbl.push_back(mk(0, 2'd0, 0, 0, 1, 0, 8'h00, 2'd0, 1));
      // lanes 2/3 interleaved; lane-3 completion reloads while
      // the lane-2 word is being taken
      for (int i = 0; i < 16; i++) begin
         ln = (i % 2 == 0) ? 2'd2 : 2'd3;
         tbl.push_back(mk(1, ln, ln == 2'd2, 0, 1,
                          i >= 14, (i == 14) ? 8'hFF : 8'h00,
                          ln, 1));
      end
      tbl.push_back(mk(0, 2'd0, 0, 0, 1, 0, 8'h00, 2'd0, 1));

      // reset state
      rst_n = 1'b0;
      drive(0, 2'd0, 0, 0, 0);
      #1;
      check("rst out_valid", 32'(out_valid), 0);
      check("rst out_data", 32'(out_data), 0);
      check("rst out_lane", 32'(out_lane), 0);
      check("rst in_ready", 32'(in_ready), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post-rst in_ready", 32'(in_ready), 1);

      foreach (tbl[i])
         step($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].ln,
              tbl[i].b, tbl[i].fl, tbl[i].ordy, tbl[i].ev,
              tbl[i].ed, tbl[i].el, tbl[i].eir);

      // stall: lane 1 word 8'h55 held with out_ready=0
      for (int k = 0; k < 8; k++)
         step("stall fill", 1, 2'd1, (k % 2) == 0, 0, 0,
              k == 7, 8'h55, 2'd1, k != 7);
      for (int k = 0; k < 3; k++)
         step("stall hold", 1, 2'd1, 1, 0, 0, 1, 8'h55, 2'd1, 0);
      step("stall take", 0, 2'd1, 0, 0, 1, 0, 8'h00, 2'd0, 1);
      for (int k = 0; k < 8; k++)
         step("post-stall", 1, 2'd1, 1, 0, 1,
              k == 7, 8'hFF, 2'd1, 1);
      step("post-stall idle", 0, 2'd0, 0, 0, 1, 0, 8'h00, 2'd0, 1);

      // flush: 5 partial bits on lane 1, flush drops a beat
      for (int k = 0; k < 5; k++)
         step("flush pre", 1, 2'd1, 1, 0, 1, 0, 8'h00, 2'd0, 1);
      step("flush", 1, 2'd1, 1, 1, 1, 0, 8'h00, 2'd0, 1);
      for (int k = 0; k < 8; k++)
         step("flush post", 1, 2'd1, k == 1, 0, 1,
              k == 7, 8'h02, 2'd1, 1);
      step("flush keeps word", 0, 2'd0, 0, 1, 0,
           1, 8'h02, 2'd1, 0);
      step("flush idle", 0, 2'd0, 0, 0, 1, 0, 8'h00, 2'd0, 1);

      // async reset with partial lane 3 and pending lane 0 word
      for (int k = 0; k < 3; k++)
         step("ar part", 1, 2'd3, 1, 0, 1, 0, 8'h00, 2'd0, 1);
      for (int k = 0; k < 8; k++)
         step("ar fill", 1, 2'd0, 1, 0, 0,
              k == 7, 8'hFF, 2'd0, k != 7);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar out_valid", 32'(out_valid), 0);
      check("ar out_data", 32'(out_data), 0);
      check("ar out_lane", 32'(out_lane), 0);
      check("ar in_ready", 32'(in_ready), 1);
      drive(0, 2'd0, 0, 0, 1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++)
         step("ar post", 1, 2'd3, k == 7, 0, 1,
              k == 7, 8'h80, 2'd3, 1);
      step("ar idle", 0, 2'd0, 0, 0, 1, 0, 8'h00, 2'd0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/demux_lane_packer.md
DEMUX_LANE_PACKER -- requirements
Module: demux_lane_packer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of bits assembled per lane word (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports s0 and s1, input, 1 bit each: the lane select presented to the upstream 1:4 demux; lane = {s1,s0}.
REQ-005 The block SHALL have ports y0, y1, y2 and y3, input, 1 bit each: the upstream 1:4 demux outputs.
REQ-006 The block SHALL have port in_valid, input, 1 bit: s0/s1/y0..y3 carry a valid bit this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an input beat this cycle.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous clear of all partial lane words.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data/out_lane hold a completed word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the word this cycle.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the completed lane word, first-received bit in bit 0.
REQ-012 The block SHALL have port out_lane, output, 2 bits: the lane index of out_data.

Function
REQ-013 An input beat SHALL be accepted when in_valid && in_ready at a rising clk edge.
REQ-014 The accepted bit SHALL be y[{s1,s0}]; the y inputs of non-selected lanes are ignored.
REQ-015 Each lane SHALL keep an independent WIDTH-bit accumulator and a bit counter running 0..WIDTH-1.
REQ-016 On an accepted beat, the selected lane SHALL write the bit at position cnt and increment cnt; other lanes SHALL hold.
REQ-017 When a beat is accepted with cnt==WIDTH-1, the lane word SHALL complete: the full word (including this bit) loads into the output register, out_lane is set, out_valid=1 from the next cycle, and that lane's cnt returns to 0.
REQ-018 The output register SHALL be a two-state FSM, EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on completion; FULL->EMPTY on out_ready with no same-cycle completion; FULL->FULL with a reload when out_ready and a completion coincide.
REQ-019 in_ready SHALL be the combinational value !(out_valid && !out_ready); stalls SHALL apply to all beats, not only completing ones.
REQ-020 out_data and out_lane SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Latency from the completing accepted beat to out_valid SHALL be exactly 1 cycle; sustained throughput SHALL be 1 bit per cycle with out_ready held high.
REQ-022 flush SHALL clear every lane cnt and accumulator on the next edge and SHALL take priority over a same-cycle input beat, which is dropped; a word already in the output register SHALL be unaffected.
REQ-023 Partial words on different lanes SHALL be retained indefinitely while lane selection interleaves.

Reset
REQ-024 While rst_n=0, out_valid=0, out_data=0, out_lane=0, all accumulators=0 and all cnt=0, regardless of clk.
REQ-025 in_ready SHALL read 1 during and immediately after reset.
REQ-026 Reset asserted mid-word or with out_valid=1 SHALL discard all partial and pending words; no word is emitted on release.

Structure
REQ-027 A shared package demux_pkg SHALL hold LANES=4, the lane-index width (2), and the lane index type.
REQ-028 The per-lane accumulator and counter SHALL be one sub-module, lane_accum, instantiated four times.
REQ-029 The output FSM and the handshake logic SHALL reside in demux_lane_packer.

Verification
REQ-030 Reset, then lane 0 (s1=0,s0=0), 8 beats with bits 1,0,1,1,0,0,1,0 and out_ready=1 -> one cycle after the 8th beat out_valid=1, out_data=8'h4D, out_lane=0.
REQ-031 Interleave lane 2 and lane 3 beats, 8 each, lane 2 all y2=1 and lane 3 all y3=0 -> words 8'hFF lane 2 then 8'h00 lane 3, each in completion order.
REQ-032 With out_ready=0 and a word pending -> in_ready=0, further beats are ignored and out_data holds; raise out_ready -> the word is taken and in_ready=1 again.
REQ-033 A completion in the same cycle that out_ready takes the prior word -> out_valid stays 1, new word and lane appear with no gap.
REQ-034 Lane 1 holds 5 bits, then flush with in_valid=1 -> that beat is dropped; the next 8 lane-1 beats yield exactly one word containing only those bits.
REQ-035 Assert rst_n=0 asynchronously mid-word with out_valid=1 -> all outputs are 0 immediately; after release, 8 fresh beats produce one correct word.
